// File: rtl/dcache_mon_pkg.sv
// Shared types for the data-cache performance monitor: event-type codes and
// the per-event metadata carried alongside the address in the trace FIFO.
package dcache_mon_pkg;

  typedef enum logic [1:0] {
    RD_HIT  = 2'd0,
    RD_MISS = 2'd1,
    WR_HIT  = 2'd2,
    WR_MISS = 2'd3
  } evt_type_e;

  // The address width is a parameter of the top, so it is appended there.
  typedef struct packed {
    evt_type_e etype;
    logic      wb;
  } evt_meta_t;

endpackage

// File: rtl/mon_event_fifo.sv
// Synchronous FIFO without fall-through; full and empty are distinguished
// by a separate occupancy counter one bit wider than the pointers.
module mon_event_fifo #(
  parameter int W         = 8,
  parameter int LOG_DEPTH = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 push_i,
  input  logic [W-1:0]         din_i,
  input  logic                 pop_i,
  output logic [W-1:0]         dout_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [LOG_DEPTH:0]   count_o
);

  localparam int                 DEPTH    = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] FULL_CNT = (LOG_DEPTH + 1)'(DEPTH);

  logic [W-1:0]         mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;
  logic [LOG_DEPTH:0]   count;
  logic                 do_push;
  logic                 do_pop;

  assign empty_o = (count == '0);
  assign full_o  = (count == FULL_CNT);
  assign do_pop  = pop_i & ~empty_o;
  // A pop frees the head slot on the same edge, so a full FIFO can still accept.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count define
  // validity, and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din_i;
  end

  assign dout_o  = mem[rd_ptr];
  assign count_o = count;

endmodule

// File: rtl/dcache_perf_monitor.sv
// Passive observer of the dcache CPU port: classifies accesses, keeps
// saturating counters and logs each event into a drainable trace FIFO.
module dcache_perf_monitor
  import dcache_mon_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 32,
  parameter int LOG_DEPTH = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic                 stall_i,
  input  logic                 ctrl_idle_i,
  input  logic                 dirty_i,
  input  logic                 mem_read_i,
  input  logic                 mem_write_i,
  input  logic [ADDR_W-1:0]    addr_i,
  output logic [CNT_W-1:0]     rd_hit_o,
  output logic [CNT_W-1:0]     rd_miss_o,
  output logic [CNT_W-1:0]     wr_hit_o,
  output logic [CNT_W-1:0]     wr_miss_o,
  output logic [CNT_W-1:0]     wb_o,
  output logic                 evt_valid_o,
  input  logic                 evt_ready_i,
  output logic [1:0]           evt_type_o,
  output logic                 evt_wb_o,
  output logic [ADDR_W-1:0]    evt_addr_o,
  output logic [LOG_DEPTH:0]   evt_count_o,
  output logic                 evt_drop_o
);

  typedef struct packed {
    evt_meta_t         meta;
    logic [ADDR_W-1:0] addr;
  } evt_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic pend;
  logic acc, is_wr, miss, hit, evt;
  logic fifo_full, fifo_empty;
  evt_t push_evt, head_evt;

  assign acc   = mem_read_i | mem_write_i;
  assign is_wr = mem_write_i;
  assign miss  = en_i & acc & stall_i & ctrl_idle_i;
  // pend masks the un-stalled completion cycle of an access that already missed.
  assign hit   = en_i & acc & ~stall_i & ~pend;
  assign evt   = miss | hit;

  always_comb begin
    push_evt           = '0;
    push_evt.addr      = addr_i;
    push_evt.meta.wb   = miss & dirty_i;
    if (miss) push_evt.meta.etype = is_wr ? WR_MISS : RD_MISS;
    else      push_evt.meta.etype = is_wr ? WR_HIT  : RD_HIT;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      rd_hit_o   <= '0;
      rd_miss_o  <= '0;
      wr_hit_o   <= '0;
      wr_miss_o  <= '0;
      wb_o       <= '0;
      pend       <= 1'b0;
      evt_drop_o <= 1'b0;
    end else begin
      if (hit  && !is_wr)    rd_hit_o  <= sat_inc(rd_hit_o);
      if (hit  &&  is_wr)    wr_hit_o  <= sat_inc(wr_hit_o);
      if (miss && !is_wr)    rd_miss_o <= sat_inc(rd_miss_o);
      if (miss &&  is_wr)    wr_miss_o <= sat_inc(wr_miss_o);
      if (miss &&  dirty_i)  wb_o      <= sat_inc(wb_o);
      if (miss)                     pend <= 1'b1;
      else if (en_i && !stall_i)    pend <= 1'b0;
      if (evt && fifo_full && !evt_ready_i) evt_drop_o <= 1'b1;
    end
  end

  mon_event_fifo #(
    .W         ($bits(evt_t)),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr_i),
    .push_i  (evt & ~clr_i),
    .din_i   (push_evt),
    .pop_i   (evt_ready_i),
    .dout_o  (head_evt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (evt_count_o)
  );

  assign evt_valid_o = ~fifo_empty;
  assign evt_type_o  = fifo_empty ? 2'd0 : head_evt.meta.etype;
  assign evt_wb_o    = fifo_empty ? 1'b0 : head_evt.meta.wb;
  assign evt_addr_o  = fifo_empty ? '0   : head_evt.addr;

endmodule

// File: tb/tb_dcache_perf_monitor.sv
// Self-checking bench for dcache_perf_monitor: expected trace events are
// queued when stimulus is driven and compared as the FIFO is drained.
module tb_dcache_perf_monitor;

  localparam int ADDR_W    = 32;
  localparam int CNT_W     = 4;
  localparam int LOG_DEPTH = 3;

  logic              clk = 1'b0;
  logic              rst, en, clr, stall, idle, dirty, rd, wr, ready;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  rd_hit, rd_miss, wr_hit, wr_miss, wb;
  logic              evt_valid, evt_wb, evt_drop;
  logic [1:0]        evt_type;
  logic [ADDR_W-1:0] evt_addr;
  logic [LOG_DEPTH:0] evt_count;

  int checks   = 0;
  int failures = 0;

  // Expected events as {type, wb, addr}.
  logic [ADDR_W+2:0] exp_q[$];

  always #5 clk = ~clk;

  dcache_perf_monitor #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .LOG_DEPTH(LOG_DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .stall_i(stall),
    .ctrl_idle_i(idle), .dirty_i(dirty), .mem_read_i(rd), .mem_write_i(wr),
    .addr_i(addr), .rd_hit_o(rd_hit), .rd_miss_o(rd_miss), .wr_hit_o(wr_hit),
    .wr_miss_o(wr_miss), .wb_o(wb), .evt_valid_o(evt_valid), .evt_ready_i(ready),
    .evt_type_o(evt_type), .evt_wb_o(evt_wb), .evt_addr_o(evt_addr),
    .evt_count_o(evt_count), .evt_drop_o(evt_drop)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    en = 1'b1; clr = 1'b0; stall = 1'b0; idle = 1'b1; dirty = 1'b0;
    rd = 1'b0; wr = 1'b0; addr = '0; ready = 1'b0;
  endtask

  task automatic apply_reset();
    quiet();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic drive(input logic r, input logic w, input logic e, input logic s,
                       input logic i, input logic [ADDR_W-1:0] a);
    rd = r; wr = w; en = e; stall = s; idle = i; addr = a;
    step();
    quiet();
  endtask

  task automatic drain(input string name);
    ready = 1'b1;
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) begin
      checks++;
      if (evt_valid !== 1'b1 || {evt_type, evt_wb, evt_addr} !== exp_q[0]) begin
        failures++;
        $display("FAIL %s_head got valid=%b evt=%h exp valid=1 evt=%h",
                 name, evt_valid, {evt_type, evt_wb, evt_addr}, exp_q[0]);
      end
      step();
      void'(exp_q.pop_front());
    end
    checks++;
    if (exp_q.size() != 0 || evt_valid !== 1'b0 || evt_count !== '0) begin
      failures++;
      $display("FAIL %s_empty got valid=%b count=%0d left=%0d exp valid=0 count=0 left=0",
               name, evt_valid, evt_count, exp_q.size());
    end
    ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({rd_hit, rd_miss, wr_hit, wr_miss, wb} !== '0 || evt_valid !== 1'b0 ||
        evt_count !== '0 || evt_drop !== 1'b0 || {evt_type, evt_wb, evt_addr} !== '0) begin
      failures++;
      $display("FAIL reset got cnt=%h valid=%b count=%0d drop=%b head=%h exp all 0",
               {rd_hit, rd_miss, wr_hit, wr_miss, wb}, evt_valid, evt_count, evt_drop,
               {evt_type, evt_wb, evt_addr});
    end
  endtask

  task automatic test_read_hit();
    apply_reset();
    exp_q.push_back({2'd0, 1'b0, 32'h0});
    drive(1, 0, 1, 0, 1, 32'h0);
    checks++;
    if ({rd_hit, rd_miss, wr_hit, wr_miss, wb} !== {4'd1, 4'd0, 4'd0, 4'd0, 4'd0}) begin
      failures++;
      $display("FAIL rd_hit_cnt got %h exp %h", {rd_hit, rd_miss, wr_hit, wr_miss, wb}, 20'h10000);
    end
    drain("rd_hit");
  endtask

  task automatic test_dirty_wr_miss();
    apply_reset();
    exp_q.push_back({2'd3, 1'b1, 32'h400});
    rd = 0; wr = 1; stall = 1; idle = 1; dirty = 1; addr = 32'h400;
    step();
    idle = 0;
    repeat (10) step();
    stall = 0; idle = 1;
    step();
    quiet();
    checks++;
    if ({rd_hit, rd_miss, wr_hit, wr_miss, wb} !== {4'd0, 4'd0, 4'd0, 4'd1, 4'd1} ||
        evt_count !== 4'd1) begin
      failures++;
      $display("FAIL wr_miss_cnt got cnt=%h count=%0d exp cnt=00011 count=1",
               {rd_hit, rd_miss, wr_hit, wr_miss, wb}, evt_count);
    end
    drain("wr_miss");
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) exp_q.push_back({2'd0, 1'b0, 32'(i * 4)});
      drive(1, 0, 1, 0, 1, 32'(i * 4));
    end
    checks++;
    if (evt_count !== 4'd8 || evt_drop !== 1'b1 || rd_hit !== 4'd10) begin
      failures++;
      $display("FAIL overflow got count=%0d drop=%b rd_hit=%0d exp count=8 drop=1 rd_hit=10",
               evt_count, evt_drop, rd_hit);
    end
    drain("overflow");
  endtask

  task automatic test_full_pop();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({2'd0, 1'b0, 32'h100 + 32'(i * 4)});
      drive(1, 0, 1, 0, 1, 32'h100 + 32'(i * 4));
    end
    checks++;
    if (evt_count !== 4'd8) begin
      failures++;
      $display("FAIL full_fill got count=%0d exp 8", evt_count);
    end
    void'(exp_q.pop_front());
    exp_q.push_back({2'd0, 1'b0, 32'h200});
    ready = 1'b1;
    drive(1, 0, 1, 0, 1, 32'h200);
    checks++;
    if (evt_count !== 4'd8 || evt_drop !== 1'b0) begin
      failures++;
      $display("FAIL full_pop got count=%0d drop=%b exp count=8 drop=0", evt_count, evt_drop);
    end
    drain("full_pop");
  endtask

  task automatic test_sat_clear();
    apply_reset();
    for (int i = 0; i < 20; i++) drive(1, 0, 1, 1, 1, 32'(i));
    checks++;
    if ({rd_hit, rd_miss, wr_hit, wr_miss, wb} !== {4'd0, 4'd15, 4'd0, 4'd0, 4'd0} ||
        evt_drop !== 1'b1) begin
      failures++;
      $display("FAIL saturate got cnt=%h drop=%b exp cnt=0f000 drop=1",
               {rd_hit, rd_miss, wr_hit, wr_miss, wb}, evt_drop);
    end
    step();
    clr = 1'b1;
    drive(1, 0, 1, 0, 1, 32'h40);
    checks++;
    if ({rd_hit, rd_miss, wr_hit, wr_miss, wb} !== '0 || evt_valid !== 1'b0 ||
        evt_count !== '0 || evt_drop !== 1'b0) begin
      failures++;
      $display("FAIL clear got cnt=%h valid=%b count=%0d drop=%b exp all 0",
               {rd_hit, rd_miss, wr_hit, wr_miss, wb}, evt_valid, evt_count, evt_drop);
    end
    exp_q.push_back({2'd0, 1'b0, 32'h44});
    drive(1, 0, 1, 0, 1, 32'h44);
    checks++;
    if (rd_hit !== 4'd1) begin
      failures++;
      $display("FAIL post_clear_hit got rd_hit=%0d exp 1", rd_hit);
    end
    drain("sat_clear");
  endtask

  task automatic test_reset_mid_miss();
    apply_reset();
    rd = 1; stall = 1; idle = 1; addr = 32'h80;
    step();
    idle = 0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({rd_hit, rd_miss, wr_hit, wr_miss, wb} !== '0 || evt_valid !== 1'b0 ||
        evt_count !== '0 || evt_drop !== 1'b0 || {evt_type, evt_wb, evt_addr} !== '0) begin
      failures++;
      $display("FAIL mid_miss_reset got cnt=%h valid=%b count=%0d exp all 0",
               {rd_hit, rd_miss, wr_hit, wr_miss, wb}, evt_valid, evt_count);
    end
    quiet();
    exp_q.push_back({2'd0, 1'b0, 32'h84});
    drive(1, 0, 1, 0, 1, 32'h84);
    checks++;
    if (rd_hit !== 4'd1) begin
      failures++;
      $display("FAIL mid_miss_hit got rd_hit=%0d exp 1", rd_hit);
    end
    drain("mid_miss");
  endtask

  task automatic test_mixed();
    apply_reset();
    exp_q.push_back({2'd2, 1'b0, 32'ha0});
    drive(0, 1, 1, 0, 1, 32'ha0);
    exp_q.push_back({2'd2, 1'b0, 32'ha1});
    drive(1, 1, 1, 0, 1, 32'ha1);
    exp_q.push_back({2'd0, 1'b0, 32'ha2});
    drive(1, 0, 1, 0, 1, 32'ha2);
    drive(1, 0, 0, 0, 1, 32'ha3);
    exp_q.push_back({2'd3, 1'b0, 32'ha4});
    rd = 0; wr = 1; stall = 1; idle = 1; addr = 32'ha4;
    step();
    idle = 0;
    step();
    stall = 0; idle = 1;
    step();
    quiet();
    checks++;
    if ({rd_hit, rd_miss, wr_hit, wr_miss, wb} !== {4'd1, 4'd0, 4'd2, 4'd1, 4'd0} ||
        evt_count !== 4'd4) begin
      failures++;
      $display("FAIL mixed got cnt=%h count=%0d exp cnt=10210 count=4",
               {rd_hit, rd_miss, wr_hit, wr_miss, wb}, evt_count);
    end
    drain("mixed");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({2'd0, 1'b0, 32'h300 + 32'(i)});
      rd = 1'b1; addr = 32'h300 + 32'(i);
      step();
      checks++;
      if (evt_valid !== 1'b1 || evt_count !== 4'd1 || {evt_type, evt_wb, evt_addr} !== exp_q[0]) begin
        failures++;
        $display("FAIL b2b_%0d got valid=%b count=%0d evt=%h exp valid=1 count=1 evt=%h",
                 i, evt_valid, evt_count, {evt_type, evt_wb, evt_addr}, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    rd = 1'b0;
    step();
    checks++;
    if (evt_valid !== 1'b0 || rd_hit !== 4'd6 || evt_drop !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end got valid=%b rd_hit=%0d drop=%b exp valid=0 rd_hit=6 drop=0",
               evt_valid, rd_hit, evt_drop);
    end
    quiet();
  endtask

  initial begin
    quiet();
    rst = 1'b1;
    test_reset();
    test_read_hit();
    test_dirty_wr_miss();
    test_overflow();
    test_full_pop();
    test_sat_clear();
    test_reset_mid_miss();
    test_mixed();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
